// File: rtl/dmem_arbiter.sv
// Two-requester arbiter in front of a single-port, 1-cycle-latency data memory.
// Round-robin grants with a capped burst lock; read data is steered back to its requester.
module dmem_arbiter #(
  parameter int ADDR_W    = 10,
  parameter int MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam int DATA_W = 32;

  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;

  lock_state_t       r_state;
  logic              r_lock_owner;
  logic [7:0]        r_burst_cnt;
  logic              r_last_grant;
  logic              r_rd_vld_p1;
  logic              r_rd_id_p1;
  logic [DATA_W-1:0] r_m0_rdata;
  logic [DATA_W-1:0] r_m1_rdata;

  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_any;
  logic              w_idx;
  logic              w_owner_req;
  logic              w_owner_lock;
  logic              w_sel_we;
  logic              w_sel_lock;
  logic [8:0]        w_cnt_next;

  // Grant decision is combinational so a request can be accepted in the cycle it rises.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_owner_req = r_lock_owner ? m1_req : m0_req;
    if (!reset_n) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end else if (r_state == LOCKED) begin
      if (w_owner_req) begin
        w_gnt0 = ~r_lock_owner;
        w_gnt1 = r_lock_owner;
      end
    end else if (m0_req && m1_req) begin
      w_gnt0 = r_last_grant;
      w_gnt1 = ~r_last_grant;
    end else begin
      w_gnt0 = m0_req;
      w_gnt1 = m1_req;
    end
  end

  assign w_any        = w_gnt0 | w_gnt1;
  assign w_idx        = w_gnt1;
  assign w_owner_lock = r_lock_owner ? m1_lock : m0_lock;
  assign w_sel_we     = w_gnt1 ? m1_we : m0_we;
  assign w_sel_lock   = w_gnt1 ? m1_lock : m0_lock;
  assign w_cnt_next   = {1'b0, r_burst_cnt} + 9'd1;

  assign m0_gnt    = w_gnt0;
  assign m1_gnt    = w_gnt1;
  assign mem_en    = w_any;
  assign mem_we    = w_any & w_sel_we;
  assign mem_addr  = w_gnt1 ? m1_addr  : (w_gnt0 ? m0_addr  : '0);
  assign mem_wdata = w_gnt1 ? m1_wdata : (w_gnt0 ? m0_wdata : '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= UNLOCKED;
      r_lock_owner <= 1'b0;
      r_burst_cnt  <= 8'd0;
      r_last_grant <= 1'b1;
    end else begin
      if (w_any) r_last_grant <= w_idx;
      case (r_state)
        UNLOCKED: begin
          // With MAX_BURST == 1 the first locked beat is also the last one.
          if (w_any && w_sel_lock && (MAX_BURST > 1)) begin
            r_state      <= LOCKED;
            r_lock_owner <= w_idx;
            r_burst_cnt  <= 8'd1;
          end
        end
        LOCKED: begin
          if (!w_owner_lock) begin
            r_state     <= UNLOCKED;
            r_burst_cnt <= 8'd0;
          end else if (w_any) begin
            if (w_cnt_next >= 9'(MAX_BURST)) begin
              r_state     <= UNLOCKED;
              r_burst_cnt <= 8'd0;
            end else begin
              r_burst_cnt <= w_cnt_next[7:0];
            end
          end
        end
      endcase
    end
  end

  // Stage p1: memory returns read data one cycle after the grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_vld_p1 <= 1'b0;
      r_rd_id_p1  <= 1'b0;
      r_m0_rdata  <= '0;
      r_m1_rdata  <= '0;
    end else begin
      r_rd_vld_p1 <= w_any & ~w_sel_we;
      r_rd_id_p1  <= w_idx;
      if (r_rd_vld_p1 && !r_rd_id_p1) r_m0_rdata <= mem_rdata;
      if (r_rd_vld_p1 &&  r_rd_id_p1) r_m1_rdata <= mem_rdata;
    end
  end

  assign m0_rvalid = r_rd_vld_p1 & ~r_rd_id_p1;
  assign m1_rvalid = r_rd_vld_p1 &  r_rd_id_p1;
  assign m0_rdata  = m0_rvalid ? mem_rdata : r_m0_rdata;
  assign m1_rdata  = m1_rvalid ? mem_rdata : r_m1_rdata;

endmodule
